ibtb_gh_tracker: RTL and testbench



---
 rtl/ibtb_gh_tracker_if.sv | 35 +++
 rtl/ibtb_gh_tracker.sv | 100 ++++++++++
 tb/tb_ibtb_gh_tracker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ibtb_gh_tracker_if.sv
// Fetch/resolve/retire bus between the core pipeline and the ibtb global-history tracker.
interface ibtb_gh_tracker_if #(
  parameter int unsigned GH_BITS      = 12,
  parameter int unsigned CKPT_ENTRIES = 8
);
  localparam int unsigned IDX_W = $clog2(CKPT_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic               pred_valid;
  logic [37:0]        pred_tgt_pc38;
  logic               pred_ready;
  logic [IDX_W-1:0]   pred_ckpt_idx;
  logic [GH_BITS-1:0] read_ibtb_gh;
  logic               restore_valid;
  logic [IDX_W-1:0]   restore_ckpt_idx;
  logic [37:0]        restore_tgt_pc38;
  logic               retire_valid;
  logic [37:0]        retire_tgt_pc38;
  logic               retire_ckpt_valid;
  logic [GH_BITS-1:0] retire_ibtb_gh;
  logic               flush_valid;
  logic [CNT_W-1:0]   ckpt_count;

  modport master (
    output pred_valid, pred_tgt_pc38, restore_valid, restore_ckpt_idx, restore_tgt_pc38,
           retire_valid, retire_tgt_pc38, flush_valid,
    input  pred_ready, pred_ckpt_idx, read_ibtb_gh, retire_ckpt_valid, retire_ibtb_gh, ckpt_count
  );

  modport slave (
    input  pred_valid, pred_tgt_pc38, restore_valid, restore_ckpt_idx, restore_tgt_pc38,
           retire_valid, retire_tgt_pc38, flush_valid,
    output pred_ready, pred_ckpt_idx, read_ibtb_gh, retire_ckpt_valid, retire_ibtb_gh, ckpt_count
  );
endinterface

// File: rtl/ibtb_gh_tracker.sv
// Speculative global history for the ibtb with a per-branch checkpoint queue,
// mispredict restore, flush to architectural history and retire-side history output.
module ibtb_gh_tracker #(
  parameter int unsigned GH_BITS      = 12,
  parameter int unsigned CKPT_ENTRIES = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  ibtb_gh_tracker_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(CKPT_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [GH_BITS-1:0] gh_q, gh_d;
  logic [GH_BITS-1:0] arch_gh_q, arch_gh_d;
  logic [IDX_W-1:0]   head_q, head_d;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [GH_BITS-1:0] ckpt_q [CKPT_ENTRIES];

  logic retire_fire;
  logic pred_fire;
  logic pred_ready_c;

  function automatic logic [GH_BITS-1:0] shift_gh(input logic [GH_BITS-1:0] g,
                                                  input logic [1:0]         t);
    return {g[GH_BITS-3:0], t};
  endfunction

  assign pred_ready_c = (count_q < CNT_W'(CKPT_ENTRIES));

  // Next-state: flush beats restore beats pred; retire is applied alongside all three.
  always_comb begin
    gh_d        = gh_q;
    arch_gh_d   = arch_gh_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pred_fire   = 1'b0;
    retire_fire = bus.retire_valid && (count_q != '0);

    if (retire_fire) begin
      arch_gh_d = shift_gh(arch_gh_q, bus.retire_tgt_pc38[1:0]);
      head_d    = head_q + IDX_W'(1);
    end

    if (bus.flush_valid) begin
      gh_d    = arch_gh_d;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (bus.restore_valid) begin
      gh_d    = shift_gh(ckpt_q[bus.restore_ckpt_idx], bus.restore_tgt_pc38[1:0]);
      tail_d  = bus.restore_ckpt_idx + IDX_W'(1);
      count_d = CNT_W'(IDX_W'(bus.restore_ckpt_idx - head_q)) + CNT_W'(1)
                - CNT_W'(retire_fire);
    end else if (bus.pred_valid && pred_ready_c) begin
      pred_fire = 1'b1;
      gh_d      = shift_gh(gh_q, bus.pred_tgt_pc38[1:0]);
      tail_d    = tail_q + IDX_W'(1);
      count_d   = count_q + CNT_W'(1) - CNT_W'(retire_fire);
    end else begin
      count_d   = count_q - CNT_W'(retire_fire);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      gh_q      <= '0;
      arch_gh_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      gh_q      <= gh_d;
      arch_gh_q <= arch_gh_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Checkpoint storage is data only and carries no reset.
  always_ff @(posedge CLK) begin
    if (nRST && pred_fire) begin
      ckpt_q[tail_q] <= gh_q;
    end
  end

  assign bus.read_ibtb_gh      = gh_q;
  assign bus.ckpt_count        = count_q;
  assign bus.pred_ready        = pred_ready_c;
  assign bus.pred_ckpt_idx     = tail_q;
  assign bus.retire_ckpt_valid = (count_q != '0);
  assign bus.retire_ibtb_gh    = ckpt_q[head_q];

  logic unused_tgt_bits;
  assign unused_tgt_bits = ^{bus.pred_tgt_pc38[37:2], bus.restore_tgt_pc38[37:2],
                             bus.retire_tgt_pc38[37:2]};
endmodule

// File: tb/tb_ibtb_gh_tracker.sv
// Directed bench for ibtb_gh_tracker with hand-computed expected history values.
module tb_ibtb_gh_tracker;
  logic CLK;
  logic nRST;
  int   errors;
  int   checks;

  ibtb_gh_tracker_if #(.GH_BITS(12), .CKPT_ENTRIES(8)) bus ();

  ibtb_gh_tracker #(.GH_BITS(12), .CKPT_ENTRIES(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.pred_valid       = 1'b0;
    bus.pred_tgt_pc38    = '0;
    bus.restore_valid    = 1'b0;
    bus.restore_ckpt_idx = '0;
    bus.restore_tgt_pc38 = '0;
    bus.retire_valid     = 1'b0;
    bus.retire_tgt_pc38  = '0;
    bus.flush_valid      = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gh"},    32'(bus.read_ibtb_gh), 32'h0);
    chk({tag, "_rdy"},   32'(bus.pred_ready), 32'h1);
    chk({tag, "_idx"},   32'(bus.pred_ckpt_idx), 32'h0);
    chk({tag, "_cnt"},   32'(bus.ckpt_count), 32'h0);
    chk({tag, "_rcv"},   32'(bus.retire_ckpt_valid), 32'h0);
  endtask

  // Restores must name an allocated slot: offset from head (= tail - count) below count.
  always @(negedge CLK) begin
    if (nRST && bus.restore_valid) begin
      logic [2:0] head_obs;
      logic [2:0] offs;
      head_obs = bus.pred_ckpt_idx - bus.ckpt_count[2:0];
      offs     = bus.restore_ckpt_idx - head_obs;
      checks++;
      assert (4'(offs) < bus.ckpt_count) else begin
        errors++;
        $error("FAIL restore_legal observed_idx=%0d expected_below_offset=%0d",
               bus.restore_ckpt_idx, bus.ckpt_count);
      end
    end
  end

  initial begin
    logic [11:0] exp_gh [8];
    exp_gh = '{12'h00C, 12'h031, 12'h0C6, 12'h31B, 12'hC6C, 12'h1B1, 12'h6C6, 12'hB1B};
    errors = 0;
    checks = 0;
    clear_in();
    nRST = 1'b0;
    cyc();
    cyc();
    nRST = 1'b1;
    cyc();
    chk_reset_state("reset");

    // Two predictions: 2'b11 then 2'b01.
    bus.pred_valid = 1'b1; bus.pred_tgt_pc38 = 38'h12_3456_7803;
    cyc();
    chk("p1_gh",  32'(bus.read_ibtb_gh), 32'h003);
    chk("p1_idx", 32'(bus.pred_ckpt_idx), 32'h1);
    chk("p1_cnt", 32'(bus.ckpt_count), 32'h1);
    chk("p1_rcv", 32'(bus.retire_ckpt_valid), 32'h1);
    chk("p1_rgh", 32'(bus.retire_ibtb_gh), 32'h000);
    bus.pred_tgt_pc38 = 38'h3F_0000_0001;
    cyc();
    chk("p2_gh",  32'(bus.read_ibtb_gh), 32'h00D);
    chk("p2_idx", 32'(bus.pred_ckpt_idx), 32'h2);
    chk("p2_cnt", 32'(bus.ckpt_count), 32'h2);

    // Restore idx 1 with 2'b10, pred in the same cycle is dropped.
    bus.pred_tgt_pc38 = 38'h3;
    bus.restore_valid = 1'b1; bus.restore_ckpt_idx = 3'd1; bus.restore_tgt_pc38 = 38'h2;
    cyc();
    clear_in();
    chk("rs_gh",  32'(bus.read_ibtb_gh), 32'h00E);
    chk("rs_cnt", 32'(bus.ckpt_count), 32'h2);
    chk("rs_idx", 32'(bus.pred_ckpt_idx), 32'h2);

    // Retire 2'b11 (arch_gh -> 0x003), then flush.
    bus.retire_valid = 1'b1; bus.retire_tgt_pc38 = 38'h7;
    #1;
    chk("rt_rgh_during", 32'(bus.retire_ibtb_gh), 32'h000);
    cyc();
    clear_in();
    chk("rt_cnt", 32'(bus.ckpt_count), 32'h1);
    chk("rt_rgh_next", 32'(bus.retire_ibtb_gh), 32'h003);
    bus.flush_valid = 1'b1;
    cyc();
    clear_in();
    chk("fl_gh",  32'(bus.read_ibtb_gh), 32'h003);
    chk("fl_cnt", 32'(bus.ckpt_count), 32'h0);
    chk("fl_idx", 32'(bus.pred_ckpt_idx), 32'h0);
    chk("fl_rcv", 32'(bus.retire_ckpt_valid), 32'h0);

    // Fill all 8 slots with targets 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      bus.pred_valid = 1'b1; bus.pred_tgt_pc38 = 38'(i);
      cyc();
      chk($sformatf("fill%0d_gh", i),  32'(bus.read_ibtb_gh), 32'(exp_gh[i]));
      chk($sformatf("fill%0d_cnt", i), 32'(bus.ckpt_count), 32'(i + 1));
      chk($sformatf("fill%0d_idx", i), 32'(bus.pred_ckpt_idx), 32'((i + 1) % 8));
    end
    chk("full_rdy", 32'(bus.pred_ready), 32'h0);

    // Ninth pred while full is refused.
    bus.pred_tgt_pc38 = 38'h1;
    cyc();
    clear_in();
    chk("full_gh",  32'(bus.read_ibtb_gh), 32'hB1B);
    chk("full_cnt", 32'(bus.ckpt_count), 32'h8);
    chk("full_rgh", 32'(bus.retire_ibtb_gh), 32'h003);

    // One retire (2'b10, arch_gh 0x003 -> 0x00E) frees a slot; next allocation wraps to 0.
    bus.retire_valid = 1'b1; bus.retire_tgt_pc38 = 38'h2;
    cyc();
    clear_in();
    chk("free_rdy", 32'(bus.pred_ready), 32'h1);
    chk("free_cnt", 32'(bus.ckpt_count), 32'h7);
    chk("free_rgh", 32'(bus.retire_ibtb_gh), 32'h00C);
    chk("wrap_idx", 32'(bus.pred_ckpt_idx), 32'h0);
    bus.pred_valid = 1'b1; bus.pred_tgt_pc38 = 38'h2;
    cyc();
    clear_in();
    chk("wrap_gh",  32'(bus.read_ibtb_gh), 32'hC6E);
    chk("wrap_cnt", 32'(bus.ckpt_count), 32'h8);
    chk("wrap_rdy", 32'(bus.pred_ready), 32'h0);

    // Restore and retire at the head (idx 1) together empty the queue; arch_gh -> 0x03B.
    bus.restore_valid = 1'b1; bus.restore_ckpt_idx = 3'd1; bus.restore_tgt_pc38 = 38'h1;
    bus.retire_valid  = 1'b1; bus.retire_tgt_pc38  = 38'h3;
    cyc();
    clear_in();
    chk("rr_gh",  32'(bus.read_ibtb_gh), 32'h031);
    chk("rr_cnt", 32'(bus.ckpt_count), 32'h0);
    chk("rr_rcv", 32'(bus.retire_ckpt_valid), 32'h0);
    chk("rr_idx", 32'(bus.pred_ckpt_idx), 32'h2);

    // Flush alongside a retire takes the post-retire architectural history.
    bus.pred_valid = 1'b1; bus.pred_tgt_pc38 = 38'h0;
    cyc();
    clear_in();
    chk("pf_gh",  32'(bus.read_ibtb_gh), 32'h0C4);
    chk("pf_rgh", 32'(bus.retire_ibtb_gh), 32'h031);
    bus.retire_valid = 1'b1; bus.retire_tgt_pc38 = 38'h1;
    bus.flush_valid  = 1'b1;
    cyc();
    clear_in();
    chk("fr_gh",  32'(bus.read_ibtb_gh), 32'h0ED);
    chk("fr_cnt", 32'(bus.ckpt_count), 32'h0);
    chk("fr_idx", 32'(bus.pred_ckpt_idx), 32'h0);

    // Reset mid-stream with a pred pending.
    bus.pred_valid = 1'b1; bus.pred_tgt_pc38 = 38'h3;
    cyc();
    chk("pre_rst_gh", 32'(bus.read_ibtb_gh), 32'h3B7);
    nRST = 1'b0;
    cyc();
    chk_reset_state("midrst");
    nRST = 1'b1;
    clear_in();
    cyc();
    chk_reset_state("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
